// File: rtl/data_mem_lanes.sv
// data_mem_lanes: byte-lane data memory, valid/ready request/response.
// Optional macro DATA_MEM_MISALIGN_TRAP_EN rejects misaligned accesses.
module data_mem_lanes #(
    parameter int LANES = 4,
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [LANES-1:0]   req_sel,
    input  logic [AW-1:0]      req_addr,
    input  logic [8*LANES-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [8*LANES-1:0] rsp_rdata,
    output logic               rsp_err
);

    localparam int DW  = 8 * LANES;
    localparam int OW  = $clog2(LANES);
    localparam int OWS = (OW > 0) ? OW : 1;
    localparam int RW  = $clog2(DEPTH);
    localparam int AB  = OW + RW;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             we_q;
    logic [LANES-1:0] sel_q;
    logic [AB-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;

    logic [OWS-1:0] off_q;
    logic [RW-1:0]  row_q;
    logic           mis;
    logic           acc;
    logic           wr_go;
    logic [7:0]     rd_lane [LANES];
    logic [DW-1:0]  rd_rot;

    // Upper address bits alias; only the low AB bits are kept.
    logic unused_addr;
    assign unused_addr = ^req_addr;

    assign off_q = OWS'(addr_q & AB'(LANES - 1));
    assign row_q = addr_q[AB-1:OW];
    assign acc   = (state_q == ACCESS);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    assign mis = (off_q != '0);
`else
    assign mis = 1'b0;
`endif

    assign wr_go = acc & we_q & ~mis;

    // Each lane gets its own row so a row-crossing access costs no extra cycle.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0]     mem [DEPTH];
        logic [OWS-1:0] bi;
        logic [RW-1:0]  row_l;

        assign bi    = OWS'(l) - off_q;
        assign row_l = (OWS'(l) < off_q) ? row_q + RW'(1) : row_q;

        // Lane write; contents are deliberately not reset.
        always_ff @(posedge clk) begin
            if (wr_go && sel_q[bi]) begin
                mem[row_l] <= wdata_q[8*bi +: 8];
            end
        end

        assign rd_lane[l] = mem[row_l];
    end

    // Rotate lane data so byte i of the result is mem[addr+i].
    always_comb begin
        rd_rot = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_rot[8*i +: 8] = rd_lane[OWS'(i) + off_q];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs, decoded from state only.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request capture and response data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                sel_q   <= req_sel;
                addr_q  <= req_addr[AB-1:0];
                wdata_q <= req_wdata;
            end
            if (acc) begin
                rsp_rdata <= (we_q || mis) ? '0 : rd_rot;
            end
        end
    end

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    logic err_q;

    // Error flag follows the response data it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (acc) begin
            err_q <= mis;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_lanes.sv
// tb_data_mem_lanes: directed vectors with a response scoreboard.
// Honours DATA_MEM_MISALIGN_TRAP_EN for the misaligned vectors.
module tb_data_mem_lanes;

    localparam int LANES = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [LANES-1:0] req_sel;
    logic [AW-1:0]    req_addr;
    logic [DW-1:0]    req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;

    data_mem_lanes #(
        .LANES(LANES),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_sel  (req_sel),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    typedef struct {
        logic [DW-1:0] rd;
        logic          err;
        int            rcyc;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_pass = 0;
    int   n_chk  = 0;
    bit   in_rsp = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act,
                                  logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: latency on first rsp_valid, data on each handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_rsp = 0;
            end else if (rsp_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_rsp: rdata 0x%0h, none queued",
                             rsp_rdata);
                end else begin
                    if (!in_rsp) begin
                        check({sb[0].name, "_lat"},
                              64'(cyc - sb[0].rcyc), 64'd2);
                        in_rsp = 1;
                    end
                    if (rsp_ready) begin
                        e = sb.pop_front();
                        check({e.name, "_rd"}, 64'(rsp_rdata), 64'(e.rd));
                        check({e.name, "_err"}, 64'(rsp_err), 64'(e.err));
                        in_rsp = 0;
                    end
                end
            end
        end
    end

    task automatic issue(string name, logic we, logic [LANES-1:0] sel,
                         logic [AW-1:0] addr, logic [DW-1:0] wd,
                         logic [DW-1:0] exp_rd, logic exp_err);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_chk++;
            $display("FAIL %s_timeout: req_ready 0 want 1", name);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_sel   = sel;
        req_addr  = addr;
        req_wdata = wd;
        e.rd   = exp_rd;
        e.err  = exp_err;
        e.rcyc = cyc;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_sel   = '0;
        req_wdata = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: %0d left want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time 200000 reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_sel   = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        rst_n = 1'b1;

        issue("st_al", 1, 4'b1111, 32'h8, 32'h11223344, 32'h0, 0);
        issue("ld_al", 0, 4'b1111, 32'h8, 32'h0, 32'h11223344, 0);
        issue("st_sel0", 1, 4'b0000, 32'h8, 32'hDEADBEEF, 32'h0, 0);
        issue("ld_sel0", 0, 4'b1111, 32'h8, 32'h0, 32'h11223344, 0);
        issue("ld_alias", 0, 4'b1111, 32'h1008, 32'h0, 32'h11223344, 0);
        issue("st_z10", 1, 4'b1111, 32'h10, 32'h0, 32'h0, 0);
        issue("st_part", 1, 4'b0101, 32'h10, 32'hFFFFFFFF, 32'h0, 0);
        issue("ld_part", 0, 4'b1111, 32'h10, 32'h0, 32'h00FF00FF, 0);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
        issue("st_z0", 1, 4'b1111, 32'h0, 32'h0, 32'h0, 0);
        issue("st_trap", 1, 4'b1111, 32'h1, 32'h12345678, 32'h0, 1);
        issue("ld_notw", 0, 4'b1111, 32'h0, 32'h0, 32'h0, 0);
        issue("ld_trap2", 0, 4'b1111, 32'h2, 32'h0, 32'h0, 1);
        issue("ld_trap3f", 0, 4'b1111, 32'h3F, 32'h0, 32'h0, 1);
`else
        issue("st_z0", 1, 4'b1111, 32'h0, 32'h0, 32'h0, 0);
        issue("st_z4", 1, 4'b1111, 32'h4, 32'h0, 32'h0, 0);
        issue("st_x3", 1, 4'b1111, 32'h3, 32'hDDCCBBAA, 32'h0, 0);
        issue("ld_x0", 0, 4'b1111, 32'h0, 32'h0, 32'hAA000000, 0);
        issue("ld_x4", 0, 4'b1111, 32'h4, 32'h0, 32'h00DDCCBB, 0);
        issue("ld_x5", 0, 4'b1111, 32'h5, 32'h0, 32'h4400DDCC, 0);
        issue("st_w0", 1, 4'b1111, 32'h0, 32'h0, 32'h0, 0);
        issue("st_w3c", 1, 4'b1111, 32'h3C, 32'h0, 32'h0, 0);
        issue("st_wrap", 1, 4'b1111, 32'h3E, 32'h44332211, 32'h0, 0);
        issue("ld_w3c", 0, 4'b1111, 32'h3C, 32'h0, 32'h22110000, 0);
        issue("ld_w0", 0, 4'b1111, 32'h0, 32'h0, 32'h00004433, 0);
        issue("ld_w3f", 0, 4'b1111, 32'h3F, 32'h0, 32'h00443322, 0);
        issue("st_wp", 1, 4'b1010, 32'h3E, 32'hAABBCCDD, 32'h0, 0);
        issue("ld_wp3c", 0, 4'b1111, 32'h3C, 32'h0, 32'hCC110000, 0);
        issue("ld_wp0", 0, 4'b1111, 32'h0, 32'h0, 32'h0000AA33, 0);
`endif

        drain();
        rsp_ready = 1'b0;
        issue("ld_bp", 0, 4'b1111, 32'h8, 32'h0, 32'h11223344, 0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rdata", 64'(rsp_rdata), 64'h11223344);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_ready0", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("bp_rel_ready1", 64'(req_ready), 64'd1);

        drain();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_sel   = 4'b1111;
        req_addr  = 32'h8;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_access", 64'(req_ready), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 64'(rsp_valid), 64'd0);
        check("rst_mid_ready", 64'(req_ready), 64'd1);
        rst_n = 1'b1;
        issue("ld_post_rst", 0, 4'b1111, 32'h8, 32'h0, 32'h11223344, 0);

        drain();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
